// File: rtl/spi_master_ctrl.sv
// SPI master: turns one host command into one framed SPI transaction
// (3 command bits + 8 payload bits), capturing a MISO byte for read-data frames.
module spi_master_ctrl #(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [7:0]  DUMMY_BYTE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam int unsigned WW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SHIFT,
    S_WAIT,
    S_CAPTURE,
    S_STOP
  } state_t;

  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [WW-1:0] wait_q;
  logic [10:0]   tx_q;
  logic [7:0]    rx_q;
  logic          rd_q;
  logic          ss_n_q;
  logic          mosi_q;
  logic          ready_q;
  logic          busy_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wait_q      <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rd_q        <= 1'b0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          ready_q <= 1'b1;
          if (cmd_valid && ready_q) begin
            state_q <= S_START;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            ss_n_q  <= 1'b0;
            mosi_q  <= 1'b0;
            rd_q    <= &cmd_op;
            // op[1] is sent twice so the command field reads 000/001/110/111
            tx_q    <= {cmd_op[1], cmd_op, (&cmd_op) ? DUMMY_BYTE : cmd_data};
          end
        end
        S_START: begin
          state_q <= S_SHIFT;
          cnt_q   <= '0;
          mosi_q  <= tx_q[10];
          tx_q    <= {tx_q[9:0], 1'b0};
        end
        S_SHIFT: begin
          if (cnt_q == 4'd10) begin
            cnt_q  <= '0;
            mosi_q <= 1'b0;
            if (rd_q) begin
              state_q <= S_WAIT;
              wait_q  <= '0;
            end else begin
              state_q <= S_STOP;
              ss_n_q  <= 1'b1;
            end
          end else begin
            cnt_q  <= cnt_q + 4'd1;
            mosi_q <= tx_q[10];
            tx_q   <= {tx_q[9:0], 1'b0};
          end
        end
        S_WAIT: begin
          if (wait_q == WAIT_LAST) begin
            state_q <= S_CAPTURE;
            cnt_q   <= '0;
          end else begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_CAPTURE: begin
          rx_q <= {rx_q[6:0], MISO};
          if (cnt_q == 4'd7) begin
            // the eighth sample lands directly in rsp_data together with the pulse
            state_q     <= S_STOP;
            cnt_q       <= '0;
            ss_n_q      <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= {rx_q[6:0], MISO};
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_STOP: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: behavioural SPI slave + RAM on the wire side,
// host-level reference memory model for expected read data.
module tb_spi_master_ctrl;

  localparam int unsigned RL     = 1;
  localparam int unsigned N_RAND = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       busy;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b0;

  always #5 clk = ~clk;

  spi_master_ctrl #(
    .RD_LATENCY(RL),
    .DUMMY_BYTE(8'h00)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op   (cmd_op),
    .cmd_data (cmd_data),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .busy     (busy),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO)
  );

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned busy_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired or event missing", name);
  endtask

  // ---------------- behavioural slave + RAM ----------------
  typedef struct {
    logic [10:0] bits;
    int unsigned len;
  } frame_t;

  frame_t      frames[$];
  int unsigned gaps[$];
  logic [7:0]  sram[256];
  logic [7:0]  s_waddr = '0;
  logic [7:0]  s_raddr = '0;
  logic [7:0]  s_rbyte = '0;
  logic [10:0] sbits = '0;
  int unsigned n = 0;
  int unsigned hi_run = 0;
  bit          active = 0;
  bit          seen_frame = 0;

  always @(posedge clk) begin
    #1;
    if (SS_n === 1'b0) begin
      if (!active) begin
        active = 1;
        n = 0;
        sbits = '0;
        if (seen_frame) gaps.push_back(hi_run);
      end else begin
        n++;
      end
      if (n >= 1 && n <= 11) sbits = {sbits[9:0], MOSI};
      if (n == 11) begin
        case (sbits[9:8])
          2'b00: s_waddr = sbits[7:0];
          2'b01: sram[s_waddr] = sbits[7:0];
          2'b10: s_raddr = sbits[7:0];
          default: s_rbyte = sram[s_raddr];
        endcase
      end
      if (n >= 12 + RL && n <= 19 + RL) MISO = s_rbyte[7 - (n - 12 - RL)];
      else MISO = 1'b0;
    end else begin
      if (active) begin
        frames.push_back('{bits: sbits, len: n + 1});
        active = 0;
        seen_frame = 1;
        hi_run = 0;
      end
      hi_run++;
      MISO = 1'b0;
    end
  end

  int unsigned rsp_cnt = 0;
  logic [7:0]  rsp_last = '0;

  always @(posedge clk) begin
    #1;
    if (rsp_valid === 1'b1) begin
      rsp_cnt++;
      rsp_last = rsp_data;
    end
  end

  // ---------------- host-level reference model ----------------
  logic [7:0] ref_mem[256];
  logic [7:0] ref_waddr = '0;
  logic [7:0] ref_raddr = '0;

  initial begin
    for (int i = 0; i < 256; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
  end

  task automatic ref_apply(input logic [1:0] op, input logic [7:0] d, output logic [7:0] rd);
    rd = ref_mem[ref_raddr];
    case (op)
      2'b00: ref_waddr = d;
      2'b01: ref_mem[ref_waddr] = d;
      2'b10: ref_raddr = d;
      default: ;
    endcase
  endtask

  function automatic logic [10:0] exp_bits(input logic [1:0] op, input logic [7:0] d);
    return {op[1], op, (op == 2'b11) ? 8'h00 : d};
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [7:0] d, output frame_t fr,
                         output int unsigned rdy, output int unsigned nrsp);
    bit r;
    int unsigned f0, r0;
    rdy = 0;
    nrsp = 0;
    fr.bits = '0;
    fr.len = 0;
    wait_ready(r);
    if (!r) begin
      fail_now("cmd_ready_wait");
      return;
    end
    f0 = frames.size();
    r0 = rsp_cnt;
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_data = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op = ~op;
    cmd_data = ~d;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      rdy++;
      if (busy === cmd_ready) busy_err++;
      if (cmd_ready === 1'b1) break;
    end
    if (cmd_ready !== 1'b1) begin
      fail_now("frame_end_wait");
      return;
    end
    nrsp = rsp_cnt - r0;
    check("frame_count", frames.size() - f0, 1);
    if (frames.size() > f0) fr = frames[f0];
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    logic [10:0] bits;
    int unsigned len;
    int unsigned rdy;
    int unsigned nrsp;
    logic [7:0]  rdata;
    logic [7:0]  hold;
  } vec_t;

  vec_t vecs[12];

  initial begin
    frame_t      fr;
    int unsigned rdy, nrsp, f0, g0, r0, idx, be;
    logic [7:0]  exp_rd, rd;
    logic [1:0]  b_op[4];
    logic [7:0]  b_d[4];
    logic [1:0]  op;
    logic [7:0]  d;
    bit          ok, prev;
    int unsigned fail0;

    vecs[0]  = '{2'b00, 8'hA5, 11'b000_1010_0101, 12, 14, 0, 8'h00, 8'h00};
    vecs[1]  = '{2'b00, 8'h3C, 11'b000_0011_1100, 12, 14, 0, 8'h00, 8'h00};
    vecs[2]  = '{2'b01, 8'h5A, 11'b001_0101_1010, 12, 14, 0, 8'h00, 8'h00};
    vecs[3]  = '{2'b10, 8'h3C, 11'b110_0011_1100, 12, 14, 0, 8'h00, 8'h00};
    vecs[4]  = '{2'b11, 8'hEE, 11'b111_0000_0000, 21, 23, 1, 8'h5A, 8'h5A};
    vecs[5]  = '{2'b00, 8'h10, 11'b000_0001_0000, 12, 14, 0, 8'h00, 8'h5A};
    vecs[6]  = '{2'b01, 8'hC3, 11'b001_1100_0011, 12, 14, 0, 8'h00, 8'h5A};
    vecs[7]  = '{2'b11, 8'h77, 11'b111_0000_0000, 21, 23, 1, 8'h5A, 8'h5A};
    vecs[8]  = '{2'b10, 8'h10, 11'b110_0001_0000, 12, 14, 0, 8'h00, 8'h5A};
    vecs[9]  = '{2'b11, 8'h00, 11'b111_0000_0000, 21, 23, 1, 8'hC3, 8'hC3};
    vecs[10] = '{2'b01, 8'hFF, 11'b001_1111_1111, 12, 14, 0, 8'h00, 8'hC3};
    vecs[11] = '{2'b11, 8'h5A, 11'b111_0000_0000, 21, 23, 1, 8'hFF, 8'hFF};

    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_data = '0;
    repeat (3) @(negedge clk);
    check("rst_SS_n", SS_n, 1);
    check("rst_MOSI", MOSI, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check("rel_cmd_ready", cmd_ready, 1);

    for (int i = 0; i < 12; i++) begin
      run_cmd(vecs[i].op, vecs[i].data, fr, rdy, nrsp);
      ref_apply(vecs[i].op, vecs[i].data, exp_rd);
      check($sformatf("v%0d_bits", i), fr.bits, vecs[i].bits);
      check($sformatf("v%0d_ss_low", i), fr.len, vecs[i].len);
      check($sformatf("v%0d_ready_lat", i), rdy, vecs[i].rdy);
      check($sformatf("v%0d_rsp_pulses", i), nrsp, vecs[i].nrsp);
      if (vecs[i].nrsp != 0) check($sformatf("v%0d_rsp_data", i), rsp_last, vecs[i].rdata);
      check($sformatf("v%0d_rsp_hold", i), rsp_data, vecs[i].hold);
    end

    // back-to-back with cmd_valid held high
    b_op = '{2'b00, 2'b01, 2'b10, 2'b11};
    b_d  = '{8'h77, 8'h99, 8'h77, 8'h00};
    wait_ready(ok);
    if (!ok) fail_now("b2b_ready");
    f0 = frames.size();
    g0 = gaps.size();
    r0 = rsp_cnt;
    idx = 0;
    be = 0;
    prev = 1;
    cmd_valid = 1'b1;
    cmd_op = b_op[0];
    cmd_data = b_d[0];
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (prev && idx < 4) begin
        idx++;
        if (idx < 4) begin
          cmd_op = b_op[idx];
          cmd_data = b_d[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (busy === cmd_ready) be++;
      prev = cmd_ready;
      if (idx == 4 && cmd_ready === 1'b1) break;
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) ref_apply(b_op[i], b_d[i], rd);
    check("b2b_accepts", idx, 4);
    check("b2b_frames", frames.size() - f0, 4);
    for (int i = 0; i < 4; i++)
      if (frames.size() > f0 + i)
        check($sformatf("b2b_bits%0d", i), frames[f0 + i].bits, exp_bits(b_op[i], b_d[i]));
    for (int i = 1; i < 4; i++)
      if (gaps.size() > g0 + i) check($sformatf("b2b_gap%0d", i), gaps[g0 + i], 2);
      else fail_now("b2b_gap_missing");
    check("b2b_busy_vs_ready", be, 0);
    check("b2b_rsp_pulses", rsp_cnt - r0, 1);
    check("b2b_rsp_data", rsp_last, 8'h99);

    // cmd_valid pulse mid-frame must be dropped
    wait_ready(ok);
    if (!ok) fail_now("ign_ready");
    f0 = frames.size();
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    cmd_data = 8'h42;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    ref_apply(2'b00, 8'h42, rd);
    repeat (5) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op = 2'b01;
    cmd_data = 8'hFF;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    repeat (30) @(negedge clk);
    check("ign_frames", frames.size() - f0, 1);
    if (frames.size() > f0) check("ign_bits", frames[f0].bits, 11'b000_0100_0010);
    check("ign_SS_n", SS_n, 1);
    check("ign_busy", busy, 0);
    check("ign_cmd_ready", cmd_ready, 1);

    // reset in the middle of a read-data frame
    r0 = rsp_cnt;
    check("pre_rst_rsp_data", rsp_data, 8'h99);
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    cmd_data = 8'h00;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("mid_SS_n_low", SS_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mrst_SS_n", SS_n, 1);
    check("mrst_cmd_ready", cmd_ready, 0);
    check("mrst_busy", busy, 0);
    check("mrst_rsp_data", rsp_data, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("mrst_rel_ready", cmd_ready, 1);
    repeat (10) @(negedge clk);
    check("mrst_no_rsp", rsp_cnt - r0, 0);
    check("mrst_rsp_hold", rsp_data, 8'h00);

    // randomized traffic against the reference memory
    busy_err = 0;
    fail0 = failures;
    for (int it = 0; it < N_RAND; it++) begin
      op = 2'($urandom_range(0, 3));
      if (op == 2'b00 || op == 2'b10) d = 8'($urandom_range(0, 15));
      else d = 8'($urandom);
      run_cmd(op, d, fr, rdy, nrsp);
      ref_apply(op, d, exp_rd);
      check("rand_bits", fr.bits, exp_bits(op, d));
      if (op == 2'b11) begin
        check("rand_rsp_pulses", nrsp, 1);
        check("rand_rsp_data", rsp_last, exp_rd);
      end else begin
        check("rand_no_rsp", nrsp, 0);
      end
      if (failures != fail0) break;
    end
    check("rand_busy_vs_ready", busy_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule
